// File: rtl/rf_sequencer_pkg.sv
// Shared types for the register-file micro-sequencer: FSM states, opcode classes, instruction width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_sequencer_pkg;

  localparam int INSTR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  // Major opcode, instruction bits [8:7]
  typedef enum logic [1:0] {
    OP_MOV = 2'b00,  // r[raddr] <= r0
    OP_ALU = 2'b01,  // r0 <= ALU(alu_op, r[raddr])
    OP_LUT = 2'b10,  // r0 <= LUT[lut_idx]
    OP_CTL = 2'b11   // control class, sub-op in [6:5]
  } opcode_t;

  // Control sub-op, instruction bits [6:5]
  typedef enum logic [1:0] {
    CTL_HALT  = 2'b00,
    CTL_BZ    = 2'b01,
    CTL_NOP   = 2'b10,
    CTL_UNDEF = 2'b11
  } ctl_t;

endpackage

// File: rtl/rf_decode.sv
// Combinational decode of the instruction register into opcode class, control sub-op and operand fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: ir (latched instruction) -> is_mov/is_alu/is_lut/is_ctl, ctl, raddr, alu_op, lut_idx.
module rf_decode
  import rf_sequencer_pkg::*;
#(
  parameter int D  = 4,
  parameter int LW = 5
) (
  input  logic [INSTR_W-1:0] ir,
  output logic               is_mov,
  output logic               is_alu,
  output logic               is_lut,
  output logic               is_ctl,
  output ctl_t               ctl,
  output logic [D-1:0]       raddr,
  output logic [2:0]         alu_op,
  output logic [LW-1:0]      lut_idx
);

  opcode_t op;

  assign op      = opcode_t'(ir[8:7]);
  assign ctl     = ctl_t'(ir[6:5]);

  assign is_mov  = (op == OP_MOV);
  assign is_alu  = (op == OP_ALU);
  assign is_lut  = (op == OP_LUT);
  assign is_ctl  = (op == OP_CTL);

  // Fields are extracted unconditionally; only the strobes qualify their use.
  assign raddr   = D'(ir[3:0]);
  assign alu_op  = ir[6:4];
  assign lut_idx = LW'(ir[4:0]);

endmodule

// File: rtl/rf_sequencer.sv
// Two-cycle-per-instruction micro-sequencer driving a register file, ALU and LUT from a 9-bit ROM.
// Latency: CPI = 2 (FETCH then EXEC); first strobe two cycles after start is sampled.
// Backpressure: none; start is ignored while a program is running.
// Ports: clk/reset (sync, active-high), start, instr (ROM word for pc), zero (r0==0), lut_target
//        -> pc, raddr, alu_op, lut_idx, reg_write/alu_src/lut_src strobes, busy, done, illegal.
module rf_sequencer
  import rf_sequencer_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int D    = 4,
  parameter int LW   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero,
  input  logic [PC_W-1:0]    lut_target,
  output logic [PC_W-1:0]    pc,
  output logic [D-1:0]       raddr,
  output logic [2:0]         alu_op,
  output logic [LW-1:0]      lut_idx,
  output logic               reg_write,
  output logic               alu_src,
  output logic               lut_src,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic               is_mov;
  logic               is_alu;
  logic               is_lut;
  logic               is_ctl;
  ctl_t               ctl;
  logic               exec_act;
  logic [PC_W-1:0]    pc_inc;

  rf_decode #(
    .D  (D),
    .LW (LW)
  ) u_decode (
    .ir      (ir),
    .is_mov  (is_mov),
    .is_alu  (is_alu),
    .is_lut  (is_lut),
    .is_ctl  (is_ctl),
    .ctl     (ctl),
    .raddr   (raddr),
    .alu_op  (alu_op),
    .lut_idx (lut_idx)
  );

  // Natural modulo-2**PC_W wrap: 255 + 1 -> 0 for the default width.
  assign pc_inc = pc + PC_W'(1);

  // Strobes only in EXEC, and suppressed in the very cycle reset is asserted
  // so a mid-EXEC reset never lets a write escape.
  assign exec_act  = (state == ST_EXEC) && !reset;
  assign reg_write = exec_act && is_mov;
  assign alu_src   = exec_act && is_alu;
  assign lut_src   = exec_act && is_lut;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        // A start in HALT behaves exactly like a start in IDLE: restart from pc=0.
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state   <= ST_FETCH;
            pc      <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            illegal <= 1'b0;
          end
        end

        // ROM word for the current pc is valid this cycle; capture it.
        ST_FETCH: begin
          ir    <= instr;
          state <= ST_EXEC;
        end

        ST_EXEC: begin
          state <= ST_FETCH;
          pc    <= pc_inc;
          if (is_ctl) begin
            case (ctl)
              CTL_HALT: begin
                state <= ST_HALT;
                pc    <= pc;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
              // zero is only looked at here, in the EXEC cycle of the branch.
              CTL_BZ: begin
                if (zero) pc <= lut_target;
              end
              CTL_NOP: begin
              end
              CTL_UNDEF: begin
                illegal <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed test of rf_sequencer with a combinational ROM model (instr = rom[pc]).
// Latency: n/a.
// Backpressure: n/a.
module tb_rf_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       zero;
  logic [8:0] instr;
  logic [7:0] lut_target;
  logic [7:0] pc;
  logic [3:0] raddr;
  logic [2:0] alu_op;
  logic [4:0] lut_idx;
  logic       reg_write;
  logic       alu_src;
  logic       lut_src;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [2:0] strb;

  logic [8:0] rom [256];

  int n_vec = 0;
  int n_err = 0;

  // Per-instruction expectations for the program {085, 003, 104, 180}
  localparam logic [2:0] PROG_STRB  [4] = '{3'b010, 3'b100, 3'b001, 3'b000};
  localparam logic [3:0] PROG_RADDR [4] = '{4'd5, 4'd3, 4'd4, 4'd0};
  localparam logic [4:0] PROG_LUT   [4] = '{5'd5, 5'd3, 5'd4, 5'd0};

  always #5 clk = ~clk;

  assign instr = rom[pc];
  assign strb  = {reg_write, alu_src, lut_src};

  rf_sequencer #(
    .PC_W (8),
    .D    (4),
    .LW   (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .instr      (instr),
    .zero       (zero),
    .lut_target (lut_target),
    .pc         (pc),
    .raddr      (raddr),
    .alu_op     (alu_op),
    .lut_idx    (lut_idx),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .lut_src    (lut_src),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rom_fill_halt();
    for (int i = 0; i < 256; i++) rom[i] = 9'h180;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    zero  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic load_program();
    rom_fill_halt();
    rom[0] = 9'h085;
    rom[1] = 9'h003;
    rom[2] = 9'h104;
    rom[3] = 9'h180;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    zero  = 1'b1;
    step();
    step();
    n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    n_vec++; if (strb !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", strb); end
    n_vec++; if ({raddr, alu_op, lut_idx} !== 12'h000) begin n_err++; $display("FAIL reset_fields: got %h want 000", {raddr, alu_op, lut_idx}); end
    reset = 1'b0;
    start = 1'b0;
    zero  = 1'b0;
    step();
    step();
    n_vec++; if ({busy, pc} !== 9'h000) begin n_err++; $display("FAIL idle_hold: got %h want 000", {busy, pc}); end
  endtask

  task automatic test_program();
    load_program();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if ({busy, pc, strb} !== {1'b1, 8'(i), 3'b000}) begin n_err++; $display("FAIL prog_fetch%0d: got busy/pc/strb %b/%h/%b want 1/%h/000", i, busy, pc, strb, 8'(i)); end
      step();
      n_vec++; if (strb !== PROG_STRB[i]) begin n_err++; $display("FAIL prog_strobe%0d: got %b want %b", i, strb, PROG_STRB[i]); end
      n_vec++; if ({raddr, lut_idx} !== {PROG_RADDR[i], PROG_LUT[i]}) begin n_err++; $display("FAIL prog_fields%0d: got %h/%h want %h/%h", i, raddr, lut_idx, PROG_RADDR[i], PROG_LUT[i]); end
      step();
    end
    n_vec++; if ({done, busy, pc, strb} !== {1'b1, 1'b0, 8'h03, 3'b000}) begin n_err++; $display("FAIL prog_halt: got done/busy/pc/strb %b/%b/%h/%b want 1/0/03/000", done, busy, pc, strb); end
    step();
    step();
    n_vec++; if ({done, pc} !== {1'b1, 8'h03}) begin n_err++; $display("FAIL prog_halt_hold: got done/pc %b/%h want 1/03", done, pc); end
  endtask

  // Enters from HALT with the program still loaded.
  task automatic test_start_ignored();
    start = 1'b1;
    step();
    n_vec++; if ({done, busy, pc} !== {1'b0, 1'b1, 8'h00}) begin n_err++; $display("FAIL halt_restart: got done/busy/pc %b/%b/%h want 0/1/00", done, busy, pc); end
    // start stays high through every FETCH and EXEC of the run
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (pc !== 8'(i)) begin n_err++; $display("FAIL busy_start_pc%0d: got %h want %h", i, pc, 8'(i)); end
      step();
      n_vec++; if (strb !== PROG_STRB[i]) begin n_err++; $display("FAIL busy_start_strobe%0d: got %b want %b", i, strb, PROG_STRB[i]); end
      step();
    end
    start = 1'b0;
    n_vec++; if ({done, busy, pc} !== {1'b1, 1'b0, 8'h03}) begin n_err++; $display("FAIL busy_start_halt: got done/busy/pc %b/%b/%h want 1/0/03", done, busy, pc); end
    step();
    n_vec++; if ({done, pc} !== {1'b1, 8'h03}) begin n_err++; $display("FAIL busy_start_hold: got done/pc %b/%h want 1/03", done, pc); end
  endtask

  task automatic test_branch();
    rom_fill_halt();
    rom[8'h00] = 9'h1A2;
    rom[8'h40] = 9'h1A2;
    rom[8'h41] = 9'h180;
    lut_target = 8'h40;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_vec++; if ({strb, lut_idx} !== {3'b000, 5'd2}) begin n_err++; $display("FAIL bz_exec: got strb/lut_idx %b/%h want 000/02", strb, lut_idx); end
    zero = 1'b1;
    step();
    n_vec++; if (pc !== 8'h40) begin n_err++; $display("FAIL bz_taken_pc: got %h want 40", pc); end
    // zero high during FETCH must not matter; drop it for the EXEC cycle
    step();
    zero = 1'b0;
    step();
    n_vec++; if (pc !== 8'h41) begin n_err++; $display("FAIL bz_not_taken_pc: got %h want 41", pc); end
    step();
    step();
    n_vec++; if ({done, pc} !== {1'b1, 8'h41}) begin n_err++; $display("FAIL bz_halt: got done/pc %b/%h want 1/41", done, pc); end
  endtask

  task automatic test_wrap_illegal();
    rom_fill_halt();
    rom[8'h00] = 9'h1A2;
    rom[8'hFF] = 9'h1C0;
    rom[8'h01] = 9'h1E0;
    rom[8'h02] = 9'h085;
    rom[8'h03] = 9'h180;
    lut_target = 8'hFF;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    zero  = 1'b1;
    step();
    step();
    n_vec++; if (pc !== 8'hFF) begin n_err++; $display("FAIL wrap_pc_ff: got %h want ff", pc); end
    zero = 1'b0;
    step();
    n_vec++; if (strb !== 3'b000) begin n_err++; $display("FAIL nop_strobe: got %b want 000", strb); end
    step();
    n_vec++; if ({busy, pc} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL wrap_pc_00: got busy/pc %b/%h want 1/00", busy, pc); end
    step();
    step();
    n_vec++; if (pc !== 8'h01) begin n_err++; $display("FAIL wrap_continue_pc: got %h want 01", pc); end
    step();
    n_vec++; if ({strb, illegal} !== 4'b0000) begin n_err++; $display("FAIL undef_exec: got strb/illegal %b/%b want 000/0", strb, illegal); end
    step();
    n_vec++; if ({illegal, pc} !== {1'b1, 8'h02}) begin n_err++; $display("FAIL undef_after: got illegal/pc %b/%h want 1/02", illegal, pc); end
    step();
    n_vec++; if ({strb, illegal} !== 4'b0101) begin n_err++; $display("FAIL illegal_sticky: got strb/illegal %b/%b want 010/1", strb, illegal); end
    step();
    step();
    step();
    n_vec++; if ({done, illegal} !== 2'b11) begin n_err++; $display("FAIL illegal_in_halt: got done/illegal %b%b want 11", done, illegal); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++; if ({illegal, done, busy, pc} !== {3'b001, 8'h00}) begin n_err++; $display("FAIL illegal_clear: got illegal/done/busy/pc %b/%b/%b/%h want 0/0/1/00", illegal, done, busy, pc); end
  endtask

  task automatic test_reset_mid_exec();
    load_program();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_vec++; if (strb !== 3'b010) begin n_err++; $display("FAIL pre_reset_exec: got %b want 010", strb); end
    reset = 1'b1;
    #1;
    n_vec++; if (strb !== 3'b000) begin n_err++; $display("FAIL reset_cycle_strobe: got %b want 000", strb); end
    step();
    n_vec++; if ({strb, busy, done, pc} !== {5'b00000, 8'h00}) begin n_err++; $display("FAIL mid_exec_reset: got strb/busy/done/pc %b/%b/%b/%h want 000/0/0/00", strb, busy, done, pc); end
    n_vec++; if (raddr !== 4'd0) begin n_err++; $display("FAIL mid_exec_reset_ir: got raddr %h want 0", raddr); end
    reset = 1'b0;
    step();
    step();
    n_vec++; if ({strb, busy, pc} !== {4'b0000, 8'h00}) begin n_err++; $display("FAIL post_reset_idle: got strb/busy/pc %b/%b/%h want 000/0/00", strb, busy, pc); end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    zero       = 1'b0;
    lut_target = 8'h00;
    rom_fill_halt();
    test_reset();
    test_program();
    test_start_ignored();
    test_branch();
    test_wrap_illegal();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
